mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Responder end of the MEM-stage memory request interface.
- Accepts 32-bit word read and byte-lane-masked write requests (addr, re, we, sel, wdata) from the load/store stage. Reports progress on mem_busy and mem_done, and returns read data.
- Serves each request as byte-serial accesses to an 8-bit synchronous RAM port: little-endian, 1-cycle read latency.
- Sits between stage_mem and the byte-wide external RAM.

Parameters:
- RAM_AW, 17, width of the RAM byte address. Request addresses are truncated to RAM_AW bits, so accesses wrap modulo 2^RAM_AW.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_addr  in  32  request byte address; bits [1:0] ignored, word-aligned internally
- mem_re  in  1  read request, level, held by requester until done
- mem_we  in  1  write request, level
- mem_sel  in  4  write byte-lane enables, bit k = byte lane k (bits 8k+7:8k); ignored for reads
- mem_wdata  in  32  write data, lane-aligned
- mem_rdata  out  32  assembled read word
- mem_busy  out  1  request in service
- mem_done  out  1  one-cycle completion pulse
- ram_addr  out  RAM_AW  RAM byte address
- ram_wr  out  1  RAM byte write strobe
- ram_dout  out  8  byte to RAM
- ram_din  in  8  byte from RAM, valid the cycle after its address is presented

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0 (mem_rdata, mem_busy, mem_done, ram_addr, ram_wr, ram_dout); internal latches cleared. Reset mid-operation aborts the access: no further RAM writes, no done pulse.
- States: IDLE, RD, RD_LAST, WR, DONE. A 2-bit lane counter k is used in RD and WR.
- IDLE:
  - mem_busy=0, mem_done=0, ram_wr=0.
  - On a rising edge, sample the request:
    - mem_re=1 → latch base={mem_addr[RAM_AW-1:2],2'b00}, go to RD with k=0.
    - Else mem_we=1 → latch base, mem_sel and mem_wdata, go to WR with k=0.
  - re and we both 1: treat as a read; the write is ignored.
  - Request inputs are sampled only in IDLE; changes in any other state are ignored.
- RD:
  - mem_busy=1, ram_addr=base+k.
  - If k>0, capture ram_din into byte lane k-1 of the read buffer.
  - k increments; after k=3, go to RD_LAST.
- RD_LAST:
  - mem_busy=1; capture ram_din into lane 3; go to DONE.
- WR:
  - mem_busy=1, ram_addr=base+k, ram_dout=wdata lane k, ram_wr=sel[k].
  - Fixed 4 cycles per write, including sel=0000, which performs no RAM write but still completes.
  - After k=3, go to DONE.
- DONE:
  - mem_busy=0, mem_done=1 for exactly this cycle, then back to IDLE.
  - For a read, mem_rdata is updated to the assembled word, visible in the DONE cycle; for a write it is unchanged.
  - mem_rdata holds its value until the next read completes.
- Latency, counted from the accepting edge (cycle 0):
  - Read: busy in cycles 1–5, done in cycle 6.
  - Write: busy in cycles 1–4, done in cycle 5.
- Requester contract: the requester drops re/we during the DONE cycle. A request still asserted in the following IDLE cycle is accepted again as a new request.
- Byte address arithmetic: base+k wraps modulo 2^RAM_AW. base is aligned, so no carry across the word.
- ram_addr/ram_dout are don't-care in IDLE/DONE, but ram_wr is guaranteed 0 outside WR.

Test Plan:
- Write 0xDEADBEEF, sel=1111, addr 0x100 → ram_wr in cycles 1–4 at 0x100..0x103 with EF,BE,AD,DE; busy cycles 1–4; done pulse in cycle 5.
- Read addr 0x101 after the write above → ram_addr 0x100..0x103 in cycles 1–4; mem_rdata=0xDEADBEEF with done in cycle 6; busy low in cycle 6.
- Byte write 0x5A5A5A5A, sel=0100, addr 0x102, then read 0x100 → only RAM[0x102] written; read returns 0xDE5ABEEF.
- sel=0000 write, then a write held during busy → no ram_wr pulses for the first write, done in cycle 5; the second request is accepted only in the IDLE cycle after DONE.
- Assert rst asynchronously in cycle 3 of a write with sel=1111 → busy, ram_wr and done drop immediately; RAM bytes 0x102/0x103 unchanged; the next request is served normally.
- RAM_AW=17, read addr 0x0002_0004 with mem_re and mem_we both 1 → read performed at ram_addr 0x00004..0x00007; no ram_wr asserted.

Source files
------------

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Responder end of the MEM-stage memory request interface. Each 32-bit word
// read or byte-lane-masked word write is served as four byte-serial accesses
// to an 8-bit synchronous RAM port (little-endian, one-cycle read latency).
//
// Ports:
//   i_clk        system clock, all state updates on the rising edge
//   i_rst        asynchronous active-high reset
//   i_mem_addr   request byte address (bits [1:0] ignored, truncated to RAM_AW)
//   i_mem_re     read request level, held until done
//   i_mem_we     write request level
//   i_mem_sel    write byte-lane enables, bit k = lane k
//   i_mem_wdata  lane-aligned write data
//   o_mem_rdata  last assembled read word, held until the next read completes
//   o_mem_busy   request in service
//   o_mem_done   one-cycle completion pulse
//   o_ram_addr   RAM byte address
//   o_ram_wr     RAM byte write strobe
//   o_ram_dout   byte to RAM
//   i_ram_din    byte from RAM, valid the cycle after its address
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int RAM_AW = 17
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_mem_addr,
    input  logic              i_mem_re,
    input  logic              i_mem_we,
    input  logic [3:0]        i_mem_sel,
    input  logic [31:0]       i_mem_wdata,
    output logic [31:0]       o_mem_rdata,
    output logic              o_mem_busy,
    output logic              o_mem_done,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_wr,
    output logic [7:0]        o_ram_dout,
    input  logic [7:0]        i_ram_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_LAST,
        S_WR,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_k;
    logic [1:0]          w_k_next;
    logic [RAM_AW-3:0]   r_base;     // word address; the lane counter supplies the low bits
    logic [3:0]          r_sel;
    logic [31:0]         r_wdata;
    logic [23:0]         r_rbuf;     // lanes 0..2 of the word being read
    logic [31:0]         r_rdata;

    // Only a window of the request address is used; the rest is dropped here.
    logic                w_unused_addr;
    assign w_unused_addr = ^i_mem_addr;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_k     <= 2'd0;
            r_base  <= '0;
            r_sel   <= 4'd0;
            r_wdata <= 32'd0;
            r_rbuf  <= 24'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;

            if (r_state == S_IDLE && (i_mem_re || i_mem_we)) begin
                r_base <= i_mem_addr[RAM_AW-1:2];
            end
            // Read wins when both are asserted, so write operands stay untouched.
            if (r_state == S_IDLE && !i_mem_re && i_mem_we) begin
                r_sel   <= i_mem_sel;
                r_wdata <= i_mem_wdata;
            end

            // The byte for address base+k-1 arrives while base+k is presented.
            // Shifting in from the top leaves lane 0 at the bottom after three
            // captures.
            if (r_state == S_RD && r_k != 2'd0) begin
                r_rbuf <= {i_ram_din, r_rbuf[23:8]};
            end
            if (r_state == S_RD_LAST) begin
                r_rdata <= {i_ram_din, r_rbuf};
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        o_mem_busy   = 1'b0;
        o_mem_done   = 1'b0;
        o_ram_wr     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_k_next = 2'd0;
                if (i_mem_re) begin
                    w_state_next = S_RD;
                end else if (i_mem_we) begin
                    w_state_next = S_WR;
                end
            end
            S_RD: begin
                o_mem_busy = 1'b1;
                w_k_next   = r_k + 2'd1;
                if (r_k == 2'd3) begin
                    w_state_next = S_RD_LAST;
                end
            end
            S_RD_LAST: begin
                o_mem_busy   = 1'b1;
                w_state_next = S_DONE;
            end
            S_WR: begin
                o_mem_busy = 1'b1;
                o_ram_wr   = r_sel[r_k];
                w_k_next   = r_k + 2'd1;
                if (r_k == 2'd3) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_mem_done   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_k_next     = 2'd0;
            end
        endcase
    end

    // Base is word aligned, so concatenating the lane counter never carries.
    assign o_ram_addr  = {r_base, r_k};
    assign o_mem_rdata = r_rdata;

    always_comb begin
        case (r_k)
            2'd0:    o_ram_dout = r_wdata[7:0];
            2'd1:    o_ram_dout = r_wdata[15:8];
            2'd2:    o_ram_dout = r_wdata[23:16];
            default: o_ram_dout = r_wdata[31:24];
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder with a byte-wide synchronous RAM model.
// Expected values are hand-computed per transaction.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int AW = 17;

    logic          clk;
    logic          rst;
    logic [31:0]   mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [3:0]    mem_sel;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_busy;
    logic          mem_done;
    logic [AW-1:0] ram_addr;
    logic          ram_wr;
    logic [7:0]    ram_dout;
    logic [7:0]    ram_din;

    logic [7:0]    ram [0:(1<<AW)-1];

    int n_vec = 0;
    int n_err = 0;

    mem_responder #(.RAM_AW(AW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_addr  (mem_addr),
        .i_mem_re    (mem_re),
        .i_mem_we    (mem_we),
        .i_mem_sel   (mem_sel),
        .i_mem_wdata (mem_wdata),
        .o_mem_rdata (mem_rdata),
        .o_mem_busy  (mem_busy),
        .o_mem_done  (mem_done),
        .o_ram_addr  (ram_addr),
        .o_ram_wr    (ram_wr),
        .o_ram_dout  (ram_dout),
        .i_ram_din   (ram_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wide synchronous RAM: registered read, write on strobe.
    always @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_addr] <= ram_dout;
        end
        ram_din <= ram[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request from acceptance to DONE, checking every cycle.
    task automatic run_req(input bit re, input bit we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel,
                           input logic [31:0] exp_rd);
        logic [AW-1:0] base;
        int            n;
        bit            last;
        base      = {addr[AW-1:2], 2'b00};
        n         = re ? 6 : 5;
        mem_addr  = addr;
        mem_re    = re;
        mem_we    = we;
        mem_sel   = sel;
        mem_wdata = data;
        @(posedge clk);                       // accepting edge, cycle 0
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            last = (c == n);
            check($sformatf("busy_c%0d", c), {31'd0, mem_busy}, {31'd0, !last});
            check($sformatf("done_c%0d", c), {31'd0, mem_done}, {31'd0, last});
            check($sformatf("wr_c%0d", c), {31'd0, ram_wr},
                  {31'd0, (!re && !last) ? sel[c-1] : 1'b0});
            if (c <= 4) begin
                check($sformatf("addr_c%0d", c), {15'd0, ram_addr}, {15'd0, base + AW'(c-1)});
                if (!re && sel[c-1]) begin
                    check($sformatf("dout_c%0d", c), {24'd0, ram_dout},
                          {24'd0, data[8*(c-1) +: 8]});
                end
            end
            if (last && re) begin
                check("rdata", mem_rdata, exp_rd);
            end
            if (!last) @(posedge clk);
        end
        mem_re = 1'b0;
        mem_we = 1'b0;
        $display("txn %s addr=%h wdata=%h sel=%b rdata=%h", re ? "RD" : "WR",
                 addr, data, sel, mem_rdata);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        mem_addr  = 32'd0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 4'd0;
        mem_wdata = 32'd0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
        ram[4] = 8'h11;
        ram[5] = 8'h22;
        ram[6] = 8'h33;
        ram[7] = 8'h44;

        // Reset state
        #12;
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_ctl", {29'd0, mem_busy, mem_done, ram_wr}, 32'd0);
        check("rst_ram", {7'd0, ram_addr, ram_dout}, 32'd0);
        $display("txn RESET released");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full word write, then read back from an unaligned address
        run_req(1'b0, 1'b0 | 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'd0);
        run_req(1'b1, 1'b0, 32'h0000_0101, 32'd0, 4'b0000, 32'hDEAD_BEEF);

        // Single-lane write, then read
        run_req(1'b0, 1'b1, 32'h0000_0102, 32'h5A5A_5A5A, 4'b0100, 32'd0);
        run_req(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'b0000, 32'hDE5A_BEEF);

        // sel=0000 write with the request held and changed during busy;
        // the changed request is only taken in the IDLE cycle after DONE.
        mem_addr  = 32'h0000_0100;
        mem_we    = 1'b1;
        mem_sel   = 4'b0000;
        mem_wdata = 32'h1111_1111;
        @(posedge clk);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 2) begin
                mem_addr  = 32'h0000_0200;
                mem_sel   = 4'b0001;
                mem_wdata = 32'h1234_5678;
            end
            check($sformatf("hold_busy_c%0d", c), {31'd0, mem_busy},
                  {31'd0, (c <= 4) || (c >= 7 && c <= 10)});
            check($sformatf("hold_done_c%0d", c), {31'd0, mem_done},
                  {31'd0, (c == 5) || (c == 11)});
            check($sformatf("hold_wr_c%0d", c), {31'd0, ram_wr}, {31'd0, c == 7});
            if (c == 7) begin
                check("hold_addr_c7", {15'd0, ram_addr}, 32'h0000_0200);
                check("hold_dout_c7", {24'd0, ram_dout}, 32'h0000_0078);
            end
            if (c == 11) mem_we = 1'b0;
            @(posedge clk);
        end
        #1;
        $display("txn WR held sel=0000 then WR addr=00000200 sel=0001");
        run_req(1'b1, 1'b0, 32'h0000_0200, 32'd0, 4'b0000, 32'h0000_0078);
        run_req(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'b0000, 32'hDE5A_BEEF);

        // Asynchronous reset during cycle 3 of a full write
        mem_addr  = 32'h0000_0100;
        mem_we    = 1'b1;
        mem_sel   = 4'b1111;
        mem_wdata = 32'hCAFE_F00D;
        @(posedge clk);                       // accept
        @(posedge clk);                       // cycle 2 begins
        @(posedge clk);                       // cycle 3 begins
        #2;
        check("arst_pre_wr", {31'd0, ram_wr}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_ctl", {29'd0, mem_busy, mem_done, ram_wr}, 32'd0);
        check("arst_rdata", mem_rdata, 32'd0);
        @(posedge clk);
        #2;
        check("arst_ram102", {24'd0, ram[17'h102]}, 32'h0000_005A);
        check("arst_ram103", {24'd0, ram[17'h103]}, 32'h0000_00DE);
        @(negedge clk);
        rst    = 1'b0;
        mem_we = 1'b0;
        $display("txn WR aborted by reset");
        @(posedge clk);
        #1;
        run_req(1'b1, 1'b0, 32'h0000_0100, 32'd0, 4'b0000, 32'hDE5A_F00D);

        // Address wrap and simultaneous re/we (read wins)
        run_req(1'b1, 1'b1, 32'h0002_0004, 32'hFFFF_FFFF, 4'b1111, 32'h4433_2211);
        check("wrap_no_write", {24'd0, ram[17'h4]}, 32'h0000_0011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
